nx_wfg_gen: RTL and testbench

// Parametrised multi-channel waveform/pattern generator; next generation of the single-channel WFG.

---
 rtl/nx_wfg_pkg.sv | 20 ++
 rtl/nx_wfg_chan.sv | 123 ++++++++++++
 rtl/nx_wfg_gen.sv | 70 +++++++
 tb/tb_nx_wfg_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_wfg_pkg.sv
// Shared helpers for the multi-channel waveform generator.
// Derived widths and the pattern_end clamp live here so top and channel agree.
package nx_wfg_pkg;

   localparam int MAX_CHANNELS  = 16;
   localparam int MAX_PAT_WIDTH = 64;

   function automatic int cnt_w(input int pw);
      return (pw > 1) ? $clog2(pw) : 1;
   endfunction

   function automatic int ch_w(input int ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction

   function automatic int clamp_end(input int e, input int pw);
      return (e >= pw) ? (pw - 1) : e;
   endfunction

endpackage

// File: rtl/nx_wfg_chan.sv
// One waveform channel: rate divider, pattern pointer and a shadowed config
// that is swapped in only at a wrap, an idle edge or a restart.
module nx_wfg_chan
   import nx_wfg_pkg::*;
#(
   parameter int PAT_WIDTH = 16,
   parameter int DIV_WIDTH = 8,
   parameter int CNT_W = cnt_w(PAT_WIDTH),
   parameter logic [PAT_WIDTH-1:0] INIT_PATTERN = '0,
   parameter logic [CNT_W-1:0] INIT_END = '1
) (
   input  logic                 ck,
   input  logic                 rn,
   input  logic                 en,
   input  logic                 sync,
   input  logic                 cfg_we,
   input  logic [PAT_WIDTH-1:0] cfg_pattern,
   input  logic [CNT_W-1:0]     cfg_end,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   output logic                 pending,
   output logic                 zo,
   output logic                 so
);

   typedef struct packed {
      logic [PAT_WIDTH-1:0] pattern;
      logic [CNT_W-1:0]     last;
      logic [DIV_WIDTH-1:0] div;
   } cfg_t;

   localparam logic [CNT_W-1:0] RST_END =
      CNT_W'(clamp_end(int'(INIT_END), PAT_WIDTH));

   localparam cfg_t RST_CFG = '{
      pattern: INIT_PATTERN,
      last:    RST_END,
      div:     '0
   };

   cfg_t                 act_q, act_d;
   cfg_t                 shd_q, shd_d;
   logic [CNT_W-1:0]     ptr_q, ptr_d;
   logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
   logic                 pending_q, pending_d;
   logic                 zo_q, zo_d;
   logic                 so_q, so_d;

   logic             tick;
   logic             wrap;
   logic             apply;
   logic [CNT_W-1:0] cfg_last;

   assign tick     = (div_cnt_q == act_q.div);
   assign wrap     = tick && (ptr_q == act_q.last);
   assign cfg_last = CNT_W'(clamp_end(int'(cfg_end), PAT_WIDTH));

   always_comb begin
      act_d     = act_q;
      shd_d     = shd_q;
      ptr_d     = ptr_q;
      div_cnt_d = div_cnt_q;
      pending_d = pending_q;
      zo_d      = zo_q;
      so_d      = 1'b0;
      apply     = 1'b0;

      if (sync) begin
         ptr_d     = '0;
         div_cnt_d = '0;
         apply     = pending_q;
      end else if (en) begin
         div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
         if (tick) begin
            ptr_d = wrap ? '0 : ptr_q + CNT_W'(1);
         end
         zo_d  = act_q.pattern[ptr_q];
         so_d  = wrap;
         apply = pending_q && wrap;
      end else begin
         apply = pending_q;
      end

      // Swap happens on a pattern boundary so the output never glitches.
      if (apply) begin
         act_d     = shd_q;
         ptr_d     = '0;
         div_cnt_d = '0;
         pending_d = 1'b0;
      end

      if (cfg_we) begin
         shd_d.pattern = cfg_pattern;
         shd_d.last    = cfg_last;
         shd_d.div     = cfg_div;
         pending_d     = 1'b1;
      end
   end

   always_ff @(posedge ck or negedge rn) begin
      if (!rn) begin
         act_q     <= RST_CFG;
         shd_q     <= '0;
         ptr_q     <= '0;
         div_cnt_q <= '0;
         pending_q <= 1'b0;
         zo_q      <= 1'b0;
         so_q      <= 1'b0;
      end else begin
         act_q     <= act_d;
         shd_q     <= shd_d;
         ptr_q     <= ptr_d;
         div_cnt_q <= div_cnt_d;
         pending_q <= pending_d;
         zo_q      <= zo_d;
         so_q      <= so_d;
      end
   end

   assign pending = pending_q;
   assign zo      = zo_q;
   assign so      = so_q;

endmodule

// File: rtl/nx_wfg_gen.sv
// Multi-channel pattern generator: config decode and ready steering
// in front of CHANNELS independent nx_wfg_chan instances.
module nx_wfg_gen
   import nx_wfg_pkg::*;
#(
   parameter int CHANNELS  = 4,
   parameter int PAT_WIDTH = 16,
   parameter int DIV_WIDTH = 8,
   localparam int CNT_W = cnt_w(PAT_WIDTH),
   localparam int CH_W  = ch_w(CHANNELS),
   parameter logic [CHANNELS*PAT_WIDTH-1:0] INIT_PATTERN = '0,
   parameter logic [CHANNELS*CNT_W-1:0]     INIT_END     = '1
) (
   input  logic                 CK,
   input  logic                 RN,
   input  logic                 EN,
   input  logic                 SYNC,
   input  logic                 CFG_VALID,
   output logic                 CFG_READY,
   input  logic [CH_W-1:0]      CFG_CH,
   input  logic [PAT_WIDTH-1:0] CFG_PATTERN,
   input  logic [CNT_W-1:0]     CFG_END,
   input  logic [DIV_WIDTH-1:0] CFG_DIV,
   output logic [CHANNELS-1:0]  ZO,
   output logic [CHANNELS-1:0]  SO
);

   logic [CHANNELS-1:0] pending;
   logic [CHANNELS-1:0] cfg_we;
   logic                cfg_ready;
   logic                xfer;

   // Unmapped channel ids fall through with ready held high.
   always_comb begin
      cfg_ready = 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
         if (CFG_CH == CH_W'(c)) begin
            cfg_ready = !pending[c];
         end
      end
   end

   assign CFG_READY = cfg_ready;
   assign xfer      = CFG_VALID && cfg_ready;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign cfg_we[c] = xfer && (CFG_CH == CH_W'(c));

      nx_wfg_chan #(
         .PAT_WIDTH   (PAT_WIDTH),
         .DIV_WIDTH   (DIV_WIDTH),
         .CNT_W       (CNT_W),
         .INIT_PATTERN(INIT_PATTERN[c*PAT_WIDTH +: PAT_WIDTH]),
         .INIT_END    (INIT_END[c*CNT_W +: CNT_W])
      ) u_chan (
         .ck         (CK),
         .rn         (RN),
         .en         (EN),
         .sync       (SYNC),
         .cfg_we     (cfg_we[c]),
         .cfg_pattern(CFG_PATTERN),
         .cfg_end    (CFG_END),
         .cfg_div    (CFG_DIV),
         .pending    (pending[c]),
         .zo         (ZO[c]),
         .so         (SO[c])
      );
   end

endmodule

// File: tb/tb_nx_wfg_gen.sv
// Directed + random checks of nx_wfg_gen against a time-based reference model.
module tb_nx_wfg_gen;

   localparam int CH = 3;
   localparam int PW = 12;
   localparam int DW = 4;
   localparam int CW = 4;
   localparam int HW = 2;
   localparam logic [CH*PW-1:0] IPAT = {12'h801, 12'h00F, 12'hA5C};
   localparam logic [CH*CW-1:0] IEND = {4'd2, 4'd15, 4'd5};

   logic          ck = 1'b0;
   logic          rn = 1'b0;
   logic          en = 1'b0;
   logic          sync = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [HW-1:0] cfg_ch = '0;
   logic [PW-1:0] cfg_pattern = '0;
   logic [CW-1:0] cfg_end = '0;
   logic [DW-1:0] cfg_div = '0;
   logic [CH-1:0] zo;
   logic [CH-1:0] so;

   int total = 0;
   int bad = 0;

   logic [PW-1:0] m_pat[CH];
   int            m_end[CH];
   int            m_div[CH];
   int            m_t[CH];
   bit            m_pend[CH];
   logic [PW-1:0] s_pat[CH];
   int            s_end[CH];
   int            s_div[CH];
   logic [CH-1:0] m_zo;
   logic [CH-1:0] m_so;

   nx_wfg_gen #(
      .CHANNELS    (CH),
      .PAT_WIDTH   (PW),
      .DIV_WIDTH   (DW),
      .INIT_PATTERN(IPAT),
      .INIT_END    (IEND)
   ) dut (
      .CK         (ck),
      .RN         (rn),
      .EN         (en),
      .SYNC       (sync),
      .CFG_VALID  (cfg_valid),
      .CFG_READY  (cfg_ready),
      .CFG_CH     (cfg_ch),
      .CFG_PATTERN(cfg_pattern),
      .CFG_END    (cfg_end),
      .CFG_DIV    (cfg_div),
      .ZO         (zo),
      .SO         (so)
   );

   always #5 ck = ~ck;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_ready();
      if (int'(cfg_ch) >= CH) return 1'b1;
      return !m_pend[cfg_ch];
   endfunction

   task automatic m_reset();
      logic [CH*PW-1:0] pv;
      logic [CH*CW-1:0] ev;
      int e;
      pv = IPAT;
      ev = IEND;
      for (int c = 0; c < CH; c++) begin
         m_pat[c]  = pv[c*PW +: PW];
         e         = int'(ev[c*CW +: CW]);
         m_end[c]  = (e > PW - 1) ? PW - 1 : e;
         m_div[c]  = 0;
         m_t[c]    = 0;
         m_pend[c] = 1'b0;
      end
      m_zo = '0;
      m_so = '0;
   endtask

   // Position is derived from enabled cycles elapsed since the last restart.
   task automatic m_edge(input bit xfer);
      int d, p;
      bit tk, wr, ap;
      for (int c = 0; c < CH; c++) begin
         d  = m_div[c] + 1;
         p  = (m_t[c] / d) % (m_end[c] + 1);
         tk = (m_t[c] % d) == m_div[c];
         wr = tk && (p == m_end[c]);
         ap = 1'b0;
         if (sync) begin
            m_so[c] = 1'b0;
            m_t[c]  = 0;
            ap      = m_pend[c];
         end else if (en) begin
            m_zo[c] = m_pat[c][p];
            m_so[c] = wr;
            m_t[c]  = m_t[c] + 1;
            ap      = m_pend[c] && wr;
         end else begin
            m_so[c] = 1'b0;
            ap      = m_pend[c];
         end
         if (ap) begin
            m_pat[c]  = s_pat[c];
            m_end[c]  = s_end[c];
            m_div[c]  = s_div[c];
            m_t[c]    = 0;
            m_pend[c] = 1'b0;
         end
         if (xfer && int'(cfg_ch) == c) begin
            s_pat[c]  = cfg_pattern;
            s_end[c]  = (int'(cfg_end) > PW - 1) ? PW - 1 : int'(cfg_end);
            s_div[c]  = int'(cfg_div);
            m_pend[c] = 1'b1;
         end
      end
   endtask

   task automatic cyc();
      bit xfer;
      chk("ready", cfg_ready, exp_ready());
      xfer = cfg_valid && exp_ready();
      @(posedge ck);
      m_edge(xfer);
      #1;
      chk("zo", zo, m_zo);
      chk("so", so, m_so);
   endtask

   task automatic cfg(input int ch, input logic [PW-1:0] p,
                      input int e, input int d);
      cfg_valid   = 1'b1;
      cfg_ch      = HW'(ch);
      cfg_pattern = p;
      cfg_end     = CW'(e);
      cfg_div     = DW'(d);
      cyc();
      cfg_valid   = 1'b0;
   endtask

   initial begin
      logic [11:0] z0, z1, s0, s1;
      logic [CH-1:0] zh;
      int n0, n2;

      m_reset();
      #2;
      chk("rst_zo", zo, 0);
      chk("rst_so", so, 0);
      chk("rst_ready", cfg_ready, 1);
      #10;
      rn = 1'b1;

      // ch0 0x005/end3/div0, ch1 0x001/end1/div2, applied while idle
      cfg(0, 12'h005, 3, 0);
      cfg(1, 12'h001, 1, 2);
      cyc();
      en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         z0[i] = zo[0];
         z1[i] = zo[1];
         s0[i] = so[0];
         s1[i] = so[1];
      end
      chk("alt_zo0", z0, 12'h555);
      chk("alt_so0", s0, 12'h888);
      chk("div_zo1", z1, 12'h1C7);
      chk("div_so1", s1, 12'h820);

      // reconfigure ch0 mid-pattern; ready drops until the wrap
      cyc();
      cfg(0, 12'h0F3, 7, 0);
      chk("busy_ready", cfg_ready, 0);
      for (int i = 0; i < 16; i++) cyc();

      // SYNC with a pending config, then idle holds ZO
      cfg(1, 12'h3C0, 11, 1);
      sync = 1'b1;
      cyc();
      chk("sync_so", so, 0);
      sync = 1'b0;
      zh = zo;
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("hold_zo", zo, zh);
      end

      // end clamp, unmapped channel, max divider with end=0
      cfg(0, 12'hFFF, 14, 0);
      cyc();
      cfg(2, 12'h001, 0, 15);
      cyc();
      cfg_ch = 2'd3;
      #1;
      chk("oob_ready", cfg_ready, 1);
      cfg(3, 12'h000, 0, 0);
      en = 1'b1;
      n0 = 0;
      n2 = 0;
      for (int i = 0; i < 32; i++) begin
         cyc();
         n0 += int'(so[0]);
         n2 += int'(so[2]);
      end
      chk("clamp_so0_cnt", n0, 2);
      chk("divmax_so2_cnt", n2, 2);
      chk("end0_zo2", zo[2], 1);

      for (int i = 0; i < 400; i++) begin
         en          = ($urandom_range(0, 99) < 85);
         sync        = ($urandom_range(0, 99) < 5);
         cfg_valid   = ($urandom_range(0, 99) < 30);
         cfg_ch      = HW'($urandom_range(0, 3));
         cfg_pattern = PW'($urandom);
         cfg_end     = CW'($urandom_range(0, 15));
         cfg_div     = ($urandom_range(0, 9) == 0) ? DW'(15)
                                                   : DW'($urandom_range(0, 3));
         cyc();
      end
      sync      = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;

      // asynchronous reset mid-run
      #2;
      rn = 1'b0;
      #1;
      chk("arst_zo", zo, 0);
      chk("arst_so", so, 0);
      chk("arst_ready", cfg_ready, 1);
      m_reset();
      @(negedge ck);
      rn = 1'b1;
      en = 1'b1;
      cyc();
      chk("replay_first", zo, 3'b110);
      for (int i = 0; i < 30; i++) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
